// File: rtl/medidor_eco.sv
// ---------------------------------------------------------------------------
// medidor_eco -- HC-SR04 echo-pulse range meter.
//
// Purpose:
//   The block is armed by a one-cycle start pulse that is issued together with
//   the trigger launch. It then waits for the echo pulse and measures the
//   pulse width in whole centimetres (truncated). A measurement ends in one
//   of two ways: the echo falls, or the measurement runs out of time after
//   TIMEOUT_CICLOS cycles counted from the arm. In both cases the block gives
//   a one-cycle valido strobe.
//
// Parameters:
//   CICLOS_CM      clk cycles per centimetre of range (default 1450)
//   MAX_CM         saturation value of the distance result (default 400)
//   TIMEOUT_CICLOS cycles allowed from arm to echo fall (default 950000)
//
// Ports:
//   clk          in   25 MHz clock, single domain
//   rst_n        in   synchronous, active-low reset
//   start        in   one-cycle arm pulse (only honoured when idle)
//   echo         in   raw echo pin, asynchronous to clk
//   distancia    out  [8:0] last measured range in cm
//   valido       out  one-cycle strobe when distancia and the flags update
//   fuera_rango  out  last result saturated at MAX_CM
//   timeout      out  last measurement expired
//   ocupado      out  high in every state other than REPOSO
//
// Configuration macro:
//   MEDIDOR_ECO_FILTRO_EN  when defined, adds a glitch filter after the
//                          synchronizer. The filtered echo takes a new value
//                          only after 4 equal samples in a row, which adds
//                          4 cycles of latency to both edges.
//
// Latency: valido rises 3 cycles after the first clock edge that samples
// echo=0 at the pin (7 cycles with the filter). The rising edge passes
// through the same pipeline, so the measured width is not skewed.
// ---------------------------------------------------------------------------
module medidor_eco #(
  parameter int CICLOS_CM      = 1450,
  parameter int MAX_CM         = 400,
  parameter int TIMEOUT_CICLOS = 950000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       echo,
  output logic [8:0] distancia,
  output logic       valido,
  output logic       fuera_rango,
  output logic       timeout,
  output logic       ocupado
);

  localparam int PW = (CICLOS_CM > 1) ? $clog2(CICLOS_CM) : 1;
  localparam int TW = $clog2(TIMEOUT_CICLOS + 1);

  typedef enum logic [1:0] {
    REPOSO,
    ESPERA_SUBIDA,
    MIDIENDO,
    LISTO
  } estado_t;

  // -------------------------------------------------------------------------
  // Two-flop synchronizer for the asynchronous echo pin
  // -------------------------------------------------------------------------
  logic r_sync1;
  logic r_sync2;

  // NOTE: every sequential block uses non-blocking assignments, so all flops
  // sample their inputs as they were before the clock edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= echo;
      r_sync2 <= r_sync1;
    end
  end

  // -------------------------------------------------------------------------
  // Optional glitch filter on the synchronized echo
  // -------------------------------------------------------------------------
  logic w_echo;

`ifdef MEDIDOR_ECO_FILTRO_EN
  logic       r_filt;
  logic [1:0] r_filt_cnt;

  // r_filt_cnt counts consecutive samples that differ from the current
  // filtered value. The fourth differing sample in a row flips the output.
  // A single agreeing sample clears the count, so short glitches are dropped.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_filt     <= 1'b0;
      r_filt_cnt <= 2'd0;
    end else if (r_sync2 == r_filt) begin
      r_filt_cnt <= 2'd0;
    end else if (r_filt_cnt == 2'd3) begin
      r_filt     <= r_sync2;
      r_filt_cnt <= 2'd0;
    end else begin
      r_filt_cnt <= r_filt_cnt + 2'd1;
    end
  end

  assign w_echo = r_filt;
`else
  assign w_echo = r_sync2;
`endif

  // -------------------------------------------------------------------------
  // Edge detection on the synchronized (optionally filtered) echo.
  // The edge strobes are registered. Both edges get the same extra cycle, so
  // the pulse width seen by the FSM equals the width at the pin.
  // -------------------------------------------------------------------------
  logic r_echo_d;
  logic r_subida;
  logic r_bajada;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_echo_d <= 1'b0;
      r_subida <= 1'b0;
      r_bajada <= 1'b0;
    end else begin
      r_echo_d <= w_echo;
      r_subida <= w_echo & ~r_echo_d;
      r_bajada <= ~w_echo & r_echo_d;
    end
  end

  // -------------------------------------------------------------------------
  // Counters: cycles since arm, cm prescaler and cm count
  // -------------------------------------------------------------------------
  estado_t       r_estado;
  logic [TW-1:0] r_ciclos;
  logic [PW-1:0] r_pre;
  logic [8:0]    r_cm;

  logic          w_pre_wrap;
  logic          w_cm_sat;
  logic [8:0]    w_cm_next;
  logic          w_expira;

  assign w_pre_wrap = (r_pre == PW'(CICLOS_CM - 1));
  assign w_cm_sat   = (r_cm >= 9'(MAX_CM));

  // The cm value as it will be after this cycle. The cycle that sees the
  // falling edge still counts as echo-high time, so a pulse of exactly
  // CICLOS_CM cycles gives 1 cm.
  assign w_cm_next  = (w_pre_wrap && !w_cm_sat) ? r_cm + 9'd1 : r_cm;

  // The cycle counter reads k after the k-th edge past the arm. This compare
  // therefore ends the measurement on edge arm+TIMEOUT_CICLOS.
  assign w_expira   = (r_ciclos == TW'(TIMEOUT_CICLOS - 1));

  // -------------------------------------------------------------------------
  // Control FSM with registered outputs
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_estado    <= REPOSO;
      r_ciclos    <= '0;
      r_pre       <= '0;
      r_cm        <= '0;
      distancia   <= '0;
      valido      <= 1'b0;
      fuera_rango <= 1'b0;
      timeout     <= 1'b0;
      ocupado     <= 1'b0;
    end else begin
      valido <= 1'b0;

      case (r_estado)
        REPOSO: begin
          if (start) begin
            r_estado <= ESPERA_SUBIDA;
            r_ciclos <= '0;
            r_pre    <= '0;
            r_cm     <= '0;
            ocupado  <= 1'b1;
          end
        end

        ESPERA_SUBIDA: begin
          r_ciclos <= r_ciclos + TW'(1);
          // The timeout takes priority over a late rise. Otherwise the
          // counter would step past its compare value and never expire.
          if (w_expira) begin
            r_estado    <= LISTO;
            valido      <= 1'b1;
            distancia   <= '0;
            fuera_rango <= 1'b0;
            timeout     <= 1'b1;
          end else if (r_subida) begin
            r_estado <= MIDIENDO;
            r_pre    <= '0;
            r_cm     <= '0;
          end
        end

        MIDIENDO: begin
          r_ciclos <= r_ciclos + TW'(1);
          r_pre    <= w_pre_wrap ? '0 : r_pre + PW'(1);
          r_cm     <= w_cm_next;
          // A fall in the same cycle as the timeout still yields a valid
          // range, because the echo did complete within the window.
          if (r_bajada) begin
            r_estado    <= LISTO;
            valido      <= 1'b1;
            distancia   <= w_cm_next;
            fuera_rango <= (w_cm_next == 9'(MAX_CM));
            timeout     <= 1'b0;
          end else if (w_expira) begin
            r_estado    <= LISTO;
            valido      <= 1'b1;
            distancia   <= '0;
            fuera_rango <= 1'b0;
            timeout     <= 1'b1;
          end
        end

        LISTO: begin
          r_estado <= REPOSO;
          ocupado  <= 1'b0;
        end

        default: begin
          r_estado <= REPOSO;
          ocupado  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_medidor_eco.sv
// ---------------------------------------------------------------------------
// tb_medidor_eco -- self-checking bench for medidor_eco.
//
// The DUT runs with scaled-down parameters (10 cycles/cm, 40 cm maximum,
// 3000-cycle timeout) so that every scenario stays short. The reference
// model works from the pin-level pulse description (arm, rise delay, high
// width). It predicts whether the measurement times out, the clock edge on
// which valido must appear, and the truncated, saturated range.
// ---------------------------------------------------------------------------
module tb_medidor_eco;

  localparam int C  = 10;
  localparam int MX = 40;
  localparam int T  = 3000;
`ifdef MEDIDOR_ECO_FILTRO_EN
  localparam int LAT = 7;
`else
  localparam int LAT = 3;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       echo;
  logic [8:0] distancia;
  logic       valido;
  logic       fuera_rango;
  logic       timeout;
  logic       ocupado;

  int n_checks = 0;
  int n_errors = 0;

  int         cyc       = 0;
  int         n_valido  = 0;
  int         last_cyc  = -1;
  logic [8:0] last_dist = '0;
  logic       last_fr   = 1'b0;
  logic       last_to   = 1'b0;

  medidor_eco #(
    .CICLOS_CM     (C),
    .MAX_CM        (MX),
    .TIMEOUT_CICLOS(T)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .echo       (echo),
    .distancia  (distancia),
    .valido     (valido),
    .fuera_rango(fuera_rango),
    .timeout    (timeout),
    .ocupado    (ocupado)
  );

  always #20 clk = ~clk;

  // cyc is the index of the most recent rising edge.
  always @(posedge clk) cyc++;

  // Record every valido strobe. Sampling happens on the falling edge.
  always @(negedge clk) begin
    if (valido === 1'b1) begin
      n_valido++;
      last_cyc  = cyc;
      last_dist = distancia;
      last_fr   = fuera_rango;
      last_to   = timeout;
    end
  end

  // One arm/echo measurement. The echo is first sampled high on edge arm+d,
  // stays high for n edges (n == 0: never rises), pre_high holds echo high
  // from before the arm. extra_start pulses start again mid-pulse.
  task automatic run_meas(input string name, input int d, input int n,
                          input bit pre_high, input bit extra_start);
    int         ea;
    int         base;
    int         exp_cyc;
    bit         exp_to;
    logic [8:0] exp_dist;
    bit         exp_fr;

    repeat (20) @(negedge clk);
    if (pre_high) begin
      echo = 1'b1;
      repeat (20) @(negedge clk);
    end

    start = 1'b1;
    @(posedge clk);
    #1;
    ea    = cyc;
    start = 1'b0;
    base  = n_valido;

    // Reference model
    if (pre_high || n == 0 || d + LAT >= T || d + n + LAT > T) begin
      exp_to   = 1'b1;
      exp_cyc  = ea + T;
      exp_dist = '0;
      exp_fr   = 1'b0;
    end else begin
      exp_to   = 1'b0;
      exp_cyc  = ea + d + n + LAT;
      exp_dist = 9'((n / C > MX) ? MX : n / C);
      exp_fr   = (n / C >= MX);
    end

    if (n > 0) begin
      repeat (d) @(negedge clk);
      echo = 1'b1;
      for (int i = 0; i < n; i++) begin
        @(negedge clk);
        start = extra_start && (i == n / 2);
        if (extra_start && i == n / 2) begin
          n_checks++;
          if (ocupado !== 1'b1) begin
            $display("FAIL %s ocupado_mid: got %b want 1", name, ocupado);
            n_errors++;
          end
        end
      end
      start = 1'b0;
      echo  = 1'b0;
    end

    while (cyc < exp_cyc + 4) @(negedge clk);

    n_checks++;
    if (n_valido - base !== 1) begin
      $display("FAIL %s strobes: got %0d want 1", name, n_valido - base);
      n_errors++;
    end
    n_checks++;
    if (last_cyc !== exp_cyc) begin
      $display("FAIL %s valido_edge: got arm+%0d want arm+%0d", name,
               last_cyc - ea, exp_cyc - ea);
      n_errors++;
    end
    n_checks++;
    if (last_dist !== exp_dist || last_fr !== exp_fr || last_to !== exp_to) begin
      $display("FAIL %s result: got dist=%0d fr=%b to=%b want dist=%0d fr=%b to=%b",
               name, last_dist, last_fr, last_to, exp_dist, exp_fr, exp_to);
      n_errors++;
    end
    n_checks++;
    if (distancia !== exp_dist || ocupado !== 1'b0) begin
      $display("FAIL %s hold: got dist=%0d ocupado=%b want dist=%0d ocupado=0",
               name, distancia, ocupado, exp_dist);
      n_errors++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b0;
    echo  = 1'(($urandom % 2));
    repeat (3) @(negedge clk);
    n_checks++;
    if ({distancia, valido, fuera_rango, timeout, ocupado} !== 13'd0) begin
      $display("FAIL reset_outputs: got dist=%0d v=%b fr=%b to=%b oc=%b want all 0",
               distancia, valido, fuera_rango, timeout, ocupado);
      n_errors++;
    end
    echo  = 1'b0;
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    n_checks++;
    if (n_valido !== 0 || ocupado !== 1'b0) begin
      $display("FAIL reset_idle: got strobes=%0d ocupado=%b want 0/0", n_valido, ocupado);
      n_errors++;
    end
  endtask

  task automatic test_nominal();
    run_meas("nominal_100cm", 50, 100 * C, 1'b0, 1'b0);
  endtask

  task automatic test_boundaries();
    run_meas("below_1cm", 5, C - 1, 1'b0, 1'b0);
    run_meas("exact_1cm", 5, C, 1'b0, 1'b0);
    run_meas("saturate", 10, 60 * C, 1'b0, 1'b0);
  endtask

  task automatic test_timeout();
    run_meas("never_rises", 0, 0, 1'b0, 1'b0);
    run_meas("high_at_arm", 10, 200, 1'b1, 1'b0);
    run_meas("fall_at_timeout", 50, T - 50 - LAT, 1'b0, 1'b0);
    run_meas("fall_after_timeout", 50, T - 50 - LAT + 1, 1'b0, 1'b0);
  endtask

  task automatic test_back_to_back();
    run_meas("second_start_ignored", 30, 50 * C + 3, 1'b0, 1'b1);
  endtask

  task automatic test_random();
    for (int k = 0; k < 12; k++) begin
      run_meas("random", int'($urandom_range(1, 60)), int'($urandom_range(5, 700)),
               1'b0, 1'b0);
    end
  endtask

  task automatic test_reset_mid();
    int base;
    repeat (20) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    base  = n_valido;
    repeat (5) @(negedge clk);
    echo = 1'b1;
    repeat (100) @(negedge clk);
    n_checks++;
    if (ocupado !== 1'b1) begin
      $display("FAIL reset_mid_busy: got ocupado=%b want 1", ocupado);
      n_errors++;
    end
    rst_n = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({distancia, valido, fuera_rango, timeout, ocupado} !== 13'd0) begin
      $display("FAIL reset_mid_outputs: got dist=%0d v=%b fr=%b to=%b oc=%b want all 0",
               distancia, valido, fuera_rango, timeout, ocupado);
      n_errors++;
    end
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    echo = 1'b0;
    repeat (50) @(negedge clk);
    n_checks++;
    if (n_valido !== base || ocupado !== 1'b0) begin
      $display("FAIL reset_mid_discard: got strobes=%0d ocupado=%b want 0/0",
               n_valido - base, ocupado);
      n_errors++;
    end
  endtask

`ifdef MEDIDOR_ECO_FILTRO_EN
  task automatic test_glitch();
    int ea;
    int base;
    int d;
    repeat (20) @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    ea    = cyc;
    start = 1'b0;
    base  = n_valido;
    for (int g = 0; g < 3; g++) begin
      repeat (10) @(negedge clk);
      echo = 1'b1;
      repeat (2) @(negedge clk);
      echo = 1'b0;
    end
    repeat (20) @(negedge clk);
    n_checks++;
    if (ocupado !== 1'b1 || n_valido !== base) begin
      $display("FAIL glitch_ignored: got ocupado=%b strobes=%0d want 1/0",
               ocupado, n_valido - base);
      n_errors++;
    end
    d    = cyc + 1 - ea;
    echo = 1'b1;
    repeat (100 * C) @(negedge clk);
    echo = 1'b0;
    while (cyc < ea + d + 100 * C + LAT + 4) @(negedge clk);
    n_checks++;
    if (n_valido - base !== 1 || last_cyc !== ea + d + 100 * C + LAT ||
        last_dist !== 9'd100 || last_to !== 1'b0) begin
      $display("FAIL glitch_pulse: got strobes=%0d edge=arm+%0d dist=%0d to=%b want 1 arm+%0d 100 0",
               n_valido - base, last_cyc - ea, last_dist, last_to, d + 100 * C + LAT);
      n_errors++;
    end
  endtask
`endif

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    echo  = 1'b0;
    test_reset();
    test_nominal();
    test_boundaries();
    test_timeout();
    test_back_to_back();
    test_random();
    test_reset_mid();
`ifdef MEDIDOR_ECO_FILTRO_EN
    test_glitch();
`endif
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/medidor_eco.md
MEDIDOR_ECO -- requirements
Module: medidor_eco

Interface
REQ-001 The block SHALL have parameter CICLOS_CM, default 1450, meaning clk cycles per centimetre of range (58 us at 25 MHz).
REQ-002 The block SHALL have parameter MAX_CM, default 400, meaning the saturation value of the distance result.
REQ-003 The block SHALL have parameter TIMEOUT_CICLOS, default 950000, meaning the cycles allowed from arm to echo fall (38 ms).
REQ-004 The block SHALL have port clk, input, 1 bit: 25 MHz clock, single clock domain.
REQ-005 The block SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-006 The block SHALL have port start, input, 1 bit: one-cycle arm pulse, coincident with the trigger launch.
REQ-007 The block SHALL have port echo, input, 1 bit: HC-SR04 echo pin, asynchronous.
REQ-008 The block SHALL have port distancia, output, 9 bits: last measured range in cm.
REQ-009 The block SHALL have port valido, output, 1 bit: one-cycle strobe when distancia and flags update.
REQ-010 The block SHALL have port fuera_rango, output, 1 bit: last result saturated at MAX_CM.
REQ-011 The block SHALL have port timeout, output, 1 bit: last measurement expired.
REQ-012 The block SHALL have port ocupado, output, 1 bit: high in any state other than REPOSO.

Function
REQ-013 echo SHALL pass through a 2-flop synchronizer; edges SHALL be detected on the synchronized signal only.
REQ-014 The FSM SHALL have states REPOSO, ESPERA_SUBIDA, MIDIENDO and LISTO.
REQ-015 In REPOSO, start=1 SHALL move the FSM to ESPERA_SUBIDA and clear the cycle, prescaler and cm counters.
REQ-016 start SHALL be ignored in every state except REPOSO.
REQ-017 In ESPERA_SUBIDA, a rising edge of synchronized echo SHALL move the FSM to MIDIENDO; an echo already high at arm SHALL NOT count as an edge.
REQ-018 In MIDIENDO, the prescaler SHALL count 0..CICLOS_CM-1; on wrap, the cm counter SHALL increment, saturating at MAX_CM. The result is truncated, not rounded.
REQ-019 In MIDIENDO, a falling edge of synchronized echo SHALL move the FSM to LISTO with distancia=cm counter, fuera_rango=(cm==MAX_CM) and timeout=0.
REQ-020 In ESPERA_SUBIDA or MIDIENDO, when the cycle counter since arm reaches TIMEOUT_CICLOS, the FSM SHALL move to LISTO with distancia=0, fuera_rango=0 and timeout=1.
REQ-021 LISTO SHALL last exactly one cycle with valido=1, then return to REPOSO.
REQ-022 Without the filter, valido SHALL rise exactly 3 clk cycles after the first clock edge that samples echo=0 at the pin.
REQ-023 distancia, fuera_rango and timeout SHALL hold their values until the next LISTO.
REQ-024 If a falling edge and the timeout occur in the same cycle, the falling edge SHALL win.

Reset
REQ-025 With rst_n=0 at a clock edge, the FSM SHALL enter REPOSO and all counters, synchronizer flops and outputs SHALL be 0 (distancia=0, valido=0, fuera_rango=0, timeout=0, ocupado=0).
REQ-026 A reset in any state, mid-measurement included, SHALL discard the measurement without a valido strobe.

Configuration
REQ-027 With macro MEDIDOR_ECO_FILTRO_EN defined, the synchronized echo SHALL change its filtered value only after 4 consecutive equal samples, adding 4 cycles of latency to both edges (REQ-022 becomes 7 cycles).
REQ-028 Without MEDIDOR_ECO_FILTRO_EN, the synchronized echo SHALL be used directly and no filter logic SHALL be present.

Verification
REQ-029 Scenario: start, then echo high after 500 us for 145000 cycles -> valido once, distancia=100, fuera_rango=0, timeout=0, 3 cycles after the fall.
REQ-030 Scenario: echo high for 1449 cycles -> distancia=0; echo high for 1450 cycles -> distancia=1.
REQ-031 Scenario: echo high for 700000 cycles -> distancia=400, fuera_rango=1.
REQ-032 Scenario: start with echo never rising -> valido at arm+950000 cycles, timeout=1, distancia=0.
REQ-033 Scenario: second start during MIDIENDO -> ignored, a single valido; rst_n=0 mid-MIDIENDO -> no valido, all outputs 0, ocupado=0.
REQ-034 Scenario, with MEDIDOR_ECO_FILTRO_EN: 2-cycle echo glitches in ESPERA_SUBIDA -> no transition; a clean 145000-cycle pulse -> distancia=100, valido 7 cycles after the fall.
